// File: rtl/wb_register_file_pkg.sv
// Shared write-back stage constants for the register file and its read ports.
// Module parameters default to these values.
package wb_register_file_pkg;

  localparam int WB_DATA_W    = 32;
  localparam int WB_SEL_W     = 5;
  localparam int WB_REG_COUNT = 32;

  // Index that is hard-wired to zero.
  localparam int WB_ZERO_IDX  = 0;

endpackage

// File: rtl/wb_read_port.sv
// One registered read port: bypasses a same-cycle write to the selected index
// and forces index 0 to read as zero.
module wb_read_port
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int SEL_W  = WB_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic [DATA_W-1:0] rd_stored_i,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              sel_is_zero;
  logic              bypass_hit;

  assign sel_is_zero = (rd_sel_i == SEL_W'(WB_ZERO_IDX));
  // Zero index never bypasses, so a write aimed at index 0 cannot leak through.
  assign bypass_hit  = wr_en_i && !sel_is_zero && (wr_sel_i == rd_sel_i);

  always_comb begin
    rd_data_d = rd_stored_i;
    if (sel_is_zero) begin
      rd_data_d = '0;
    end else if (bypass_hit) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wb_register_file.sv
// Write-back register file: REG_COUNT x DATA_W storage, one write port,
// two independent registered read ports with write bypass.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int SEL_W     = WB_SEL_W,
  parameter int REG_COUNT = WB_REG_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] S3_WriteData,
  input  logic [SEL_W-1:0]  S3_WriteSelect,
  input  logic              S3_WriteEnable,
  input  logic [SEL_W-1:0]  ReadSelect1,
  input  logic [SEL_W-1:0]  ReadSelect2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic              wr_fire;

  assign wr_fire = S3_WriteEnable && (S3_WriteSelect != SEL_W'(WB_ZERO_IDX));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[S3_WriteSelect] <= S3_WriteData;
    end
  end

  wb_read_port #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_read_port1 (
    .clk         (clk),
    .rst         (rst),
    .rd_sel_i    (ReadSelect1),
    .rd_stored_i (regs_q[ReadSelect1]),
    .wr_en_i     (S3_WriteEnable),
    .wr_sel_i    (S3_WriteSelect),
    .wr_data_i   (S3_WriteData),
    .rd_data_o   (ReadData1)
  );

  wb_read_port #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_read_port2 (
    .clk         (clk),
    .rst         (rst),
    .rd_sel_i    (ReadSelect2),
    .rd_stored_i (regs_q[ReadSelect2]),
    .wr_en_i     (S3_WriteEnable),
    .wr_sel_i    (S3_WriteSelect),
    .wr_data_i   (S3_WriteData),
    .rd_data_o   (ReadData2)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed vector table, reset
// priority sequence, and a random run against a behavioural model.
module tb_wb_register_file;

  logic        clk;
  logic        rst;
  logic [31:0] S3_WriteData;
  logic [4:0]  S3_WriteSelect;
  logic        S3_WriteEnable;
  logic [4:0]  ReadSelect1;
  logic [4:0]  ReadSelect2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks = 0;
  int errors = 0;

  wb_register_file dut (
    .clk            (clk),
    .rst            (rst),
    .S3_WriteData   (S3_WriteData),
    .S3_WriteSelect (S3_WriteSelect),
    .S3_WriteEnable (S3_WriteEnable),
    .ReadSelect1    (ReadSelect1),
    .ReadSelect2    (ReadSelect2),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  wsel;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called #1 after an edge), then sample #1 after the next edge.
  task automatic step(input logic r, input logic we, input logic [4:0] ws,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    rst            = r;
    S3_WriteEnable = we;
    S3_WriteSelect = ws;
    S3_WriteData   = wd;
    ReadSelect1    = r1;
    ReadSelect2    = r2;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model [32];
  logic [31:0] exp1, exp2;
  logic        r_rst, r_we;
  logic [4:0]  r_ws, r_r1, r_r2;
  logic [31:0] r_wd;

  initial begin
    rst = 1'b1;
    S3_WriteEnable = 1'b0;
    S3_WriteSelect = '0;
    S3_WriteData = '0;
    ReadSelect1 = '0;
    ReadSelect2 = '0;

    //            rst  we  wsel   wdata          rs1    rs2    exp1           exp2
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd3,  5'd0,  32'h12345678, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd9,  32'hAAAA5555, 5'd9,  5'd9,  32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd3,  32'h0,        32'h12345678};
    vecs[8]  = '{1'b0, 1'b1, 5'd31, 32'h11,       5'd31, 5'd7,  32'h11,       32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 5'd7,  32'h22,       5'd3,  5'd7,  32'h12345678, 32'h22};
    vecs[10] = '{1'b1, 1'b1, 5'd4,  32'h55,       5'd4,  5'd7,  32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,  32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd4,  5'd31, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 5'd4,  32'h99,       5'd4,  5'd0,  32'h99,       32'h0};

    @(posedge clk);
    #1;
    for (int v = 0; v < NVEC; v++) begin
      step(vecs[v].rst, vecs[v].we, vecs[v].wsel, vecs[v].wdata, vecs[v].rs1, vecs[v].rs2);
      check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].e2);
    end

    // Fill 1..31 with value=index and read them back.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("fill_rd1_idx%0d", i), ReadData1, 32'(i));
      check($sformatf("fill_rd2_idx%0d", 31 - i), ReadData2, 32'(31 - i));
    end
    // Reset wins over a same-cycle write to index 4.
    step(1'b1, 1'b1, 5'd4, 32'h55, 5'd4, 5'd4);
    check("rstwrite_rd1", ReadData1, 32'h0);
    check("rstwrite_rd2", ReadData2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("postrst_rd1_idx%0d", i), ReadData1, 32'h0);
      check($sformatf("postrst_rd2_idx%0d", 31 - i), ReadData2, 32'h0);
    end

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int c = 0; c < 1000; c++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_ws  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_r1  = ($urandom_range(0, 3) == 0) ? r_ws : 5'($urandom_range(0, 31));
      r_r2  = ($urandom_range(0, 3) == 0) ? r_r1 : 5'($urandom_range(0, 31));
      if (r_rst) begin
        exp1 = 32'h0;
        exp2 = 32'h0;
      end else begin
        exp1 = (r_r1 == 5'd0) ? 32'h0 : (r_we && r_ws == r_r1) ? r_wd : model[r_r1];
        exp2 = (r_r2 == 5'd0) ? 32'h0 : (r_we && r_ws == r_r2) ? r_wd : model[r_r2];
      end
      step(r_rst, r_we, r_ws, r_wd, r_r1, r_r2);
      check($sformatf("rand%0d_rd1", c), ReadData1, exp1);
      check($sformatf("rand%0d_rd2", c), ReadData2, exp2);
      if (r_rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (r_we && r_ws != 5'd0) begin
        model[r_ws] = r_wd;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
